layer_out_serializer: RTL and testbench

- Sits directly downstream of one layer of neuron instances.
- Captures the layer's parallel neuron outputs, all presented in the same cycle, into a holding buffer.
- Streams them one word per cycle, neuron 0 first, as the input stream for the next layer's neurons or an AXI-Stream-style sink.
- Double-buffered, so the next layer vector can be captured while the current one is still streaming.

---
 rtl/nn_stream_pkg.sv | 17 +
 rtl/argmax_tracker.sv | 32 +++
 rtl/layer_out_serializer.sv | 147 ++++++++++++++
 tb/tb_layer_out_serializer.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_stream_pkg.sv
// rtl/nn_stream_pkg.sv - shared FSM encodings, defaults and slice helpers for layer streaming
package nn_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2
    } ser_state_e;

    localparam int DEFAULT_DATA_WIDTH = 16;

    // Base bit of neuron k's word inside a flattened layer vector
    function automatic int slice_base(input int k, input int width);
        return k * width;
    endfunction

endpackage

// File: rtl/argmax_tracker.sv
// rtl/argmax_tracker.sv - running signed argmax over one streamed vector, result pulsed after last
module argmax_tracker #(
    parameter int DATA_WIDTH = 16,
    parameter int IDX_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [IDX_WIDTH-1:0]  index,
    input  logic                  last,
    output logic [IDX_WIDTH-1:0]  idx,
    output logic [DATA_WIDTH-1:0] val,
    output logic                  result_valid
);

    // Element 0 restarts the search; later elements replace only when strictly larger
    always_ff @(posedge clk) begin
        if (rst) begin
            idx          <= '0;
            val          <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= valid && last;
            if (valid && ((index == '0) || ($signed(data) > $signed(val)))) begin
                idx <= index;
                val <= data;
            end
        end
    end

endmodule

// File: rtl/layer_out_serializer.sv
// rtl/layer_out_serializer.sv - double-buffered layer vector to word stream; LAYER_SER_ARGMAX_EN adds argmax
module layer_out_serializer
    import nn_stream_pkg::*;
#(
    parameter int NUM_NEURONS = 30,
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int IDX_WIDTH   = $clog2(NUM_NEURONS)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_NEURONS-1:0]            in_valid,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_last,
    output logic                              busy,
    output logic                              overflow_err,
    output logic                              sync_err
`ifdef LAYER_SER_ARGMAX_EN
    ,
    output logic [IDX_WIDTH-1:0]              argmax_idx,
    output logic [DATA_WIDTH-1:0]             argmax_val,
    output logic                              argmax_valid
`endif
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_NEURONS - 1);

    ser_state_e             state;
    logic                   hold_full;
    logic [IDX_WIDTH-1:0]   counter;
    logic [DATA_WIDTH-1:0]  hold_buf  [NUM_NEURONS];
    logic [DATA_WIDTH-1:0]  shift_buf [NUM_NEURONS];

    logic capture;
    logic partial;
    logic load;
    logic accept;
    logic xfer;

    assign capture = &in_valid;
    assign partial = (|in_valid) && !capture;
    assign load    = (state == ST_LOAD);
    // The LOAD cycle empties the hold buffer, so a capture landing then is still safe
    assign accept  = capture && (!hold_full || load);
    assign xfer    = out_valid && out_ready;

    assign out_data = shift_buf[counter];
    assign out_last = out_valid && (counter == LAST_IDX);
    assign busy     = hold_full || (state != ST_IDLE);

    // Hold buffer: take a complete vector when there is room for it
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_full <= 1'b0;
            for (int k = 0; k < NUM_NEURONS; k++) begin
                hold_buf[k] <= '0;
            end
        end else begin
            if (accept) begin
                for (int k = 0; k < NUM_NEURONS; k++) begin
                    hold_buf[k] <= in_data[slice_base(k, DATA_WIDTH) +: DATA_WIDTH];
                end
            end
            if (accept) begin
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end
        end
    end

    // Sticky error flags: dropped vector and misaligned neuron valids
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_err <= 1'b0;
            sync_err     <= 1'b0;
        end else begin
            if (capture && hold_full && !load) begin
                overflow_err <= 1'b1;
            end
            if (partial) begin
                sync_err <= 1'b1;
            end
        end
    end

    // Stream FSM: move hold into the shift buffer, then emit one word per accepted transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            counter   <= '0;
            out_valid <= 1'b0;
            for (int k = 0; k < NUM_NEURONS; k++) begin
                shift_buf[k] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (hold_full) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    shift_buf <= hold_buf;
                    counter   <= '0;
                    out_valid <= 1'b1;
                    state     <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (xfer) begin
                        if (counter == LAST_IDX) begin
                            counter   <= '0;
                            out_valid <= 1'b0;
                            state     <= ST_IDLE;
                        end else begin
                            counter <= counter + 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef LAYER_SER_ARGMAX_EN
    argmax_tracker #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_argmax (
        .clk          (clk),
        .rst          (rst),
        .valid        (xfer),
        .data         (out_data),
        .index        (counter),
        .last         (out_last),
        .idx          (argmax_idx),
        .val          (argmax_val),
        .result_valid (argmax_valid)
    );
`endif

endmodule

// File: tb/tb_layer_out_serializer.sv
// tb/tb_layer_out_serializer.sv - directed self-checking bench for layer_out_serializer
module tb_layer_out_serializer;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic           out_last;
    logic           busy;
    logic           overflow_err;
    logic           sync_err;
`ifdef LAYER_SER_ARGMAX_EN
    logic [IW-1:0]  argmax_idx;
    logic [W-1:0]   argmax_val;
    logic           argmax_valid;
`endif

    layer_out_serializer #(
        .NUM_NEURONS (N),
        .DATA_WIDTH  (W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .busy         (busy),
        .overflow_err (overflow_err),
        .sync_err     (sync_err)
`ifdef LAYER_SER_ARGMAX_EN
        ,
        .argmax_idx   (argmax_idx),
        .argmax_val   (argmax_val),
        .argmax_valid (argmax_valid)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0] d;
        logic         l;
    } exp_t;

    exp_t         expq[$];
    exp_t         e_cur;
    logic [W-1:0] seen[$];
    int           gaps[$];

    logic         bp_mode = 1'b0;
    logic [3:0]   bp_pat  = 4'b1001;
    int           bp_i    = 0;

    logic         prev_stall = 1'b0;
    logic         prev_valid = 1'b0;
    logic [W-1:0] prev_data  = '0;
    logic         prev_last  = 1'b0;
    int           idle_run   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Model: an accepted vector yields its words low neuron first, last flag on the final one
    task automatic expect_vec(input logic [N*W-1:0] v);
        for (int k = 0; k < N; k++) begin
            expq.push_back('{d: v[k*W +: W], l: (k == N-1)});
        end
    endtask

    // Called just after a rising edge; vector is sampled on the next edge
    task automatic drive_vec(input logic [N*W-1:0] v, input logic [N-1:0] vld);
        in_data  = v;
        in_valid = vld;
        @(posedge clk);
        #1;
        in_valid = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = '0;
        expq.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        seen.delete();
        gaps.delete();
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (n < 200 && (busy || expq.size() != 0)) begin
            @(negedge clk);
            n++;
        end
        check(name, {63'd0, (!busy && expq.size() == 0)}, 64'd1);
    endtask

    task automatic check_gap(input string name);
        if (gaps.size() < 2) check({name, "_count"}, 64'(gaps.size()), 64'd2);
        else                 check(name, 64'(gaps[1]), 64'd2);
    endtask

    // Sink readiness pattern while backpressure is enabled
    always @(posedge clk) begin
        #1;
        out_ready = bp_mode ? bp_pat[bp_i % 4] : 1'b1;
        bp_i++;
    end

    // Compare process: every transfer against the model, stalls for stability, idle gaps
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
            prev_valid = 1'b0;
            idle_run   = 0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", {63'd0, out_valid}, 64'd1);
                check("hold_data", {48'd0, out_data}, {48'd0, prev_data});
                check("hold_last", {63'd0, out_last}, {63'd0, prev_last});
            end
            if (!out_valid) check("last_without_valid", {63'd0, out_last}, 64'd0);
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    check("unexpected_xfer", {48'd0, out_data}, 64'hdead);
                end else begin
                    e_cur = expq.pop_front();
                    check("data", {48'd0, out_data}, {48'd0, e_cur.d});
                    check("last", {63'd0, out_last}, {63'd0, e_cur.l});
                end
                seen.push_back(out_data);
            end
            if (out_valid && !prev_valid) gaps.push_back(idle_run);
            idle_run   = out_valid ? 0 : idle_run + 1;
            prev_stall = out_valid && !out_ready;
            prev_valid = out_valid;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [N*W-1:0] va, vb, vc;
        int n;
        rst = 1'b1;
        in_data = '0;
        in_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_data", {48'd0, out_data}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_overflow", {63'd0, overflow_err}, 64'd0);
        check("rst_sync", {63'd0, sync_err}, 64'd0);
`ifdef LAYER_SER_ARGMAX_EN
        check("rst_argmax_valid", {63'd0, argmax_valid}, 64'd0);
`endif

        // Basic stream with latency pinned: sampled at T, idle, LOAD, first word after T+2
        do_reset();
        va = 64'h0004_0003_0002_0001;
        expect_vec(va);
        drive_vec(va, 4'b1111);
        @(negedge clk);
        check("lat_t0_valid", {63'd0, out_valid}, 64'd0);
        check("lat_t0_busy", {63'd0, busy}, 64'd1);
        @(negedge clk);
        check("lat_t1_valid", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        check("lat_t2_valid", {63'd0, out_valid}, 64'd1);
        check("lat_t2_data", {48'd0, out_data}, 64'h0001);
        wait_drain("basic_drain");
        check("basic_count", 64'(seen.size()), 64'd4);
        for (int k = 0; k < 4 && k < seen.size(); k++)
            check("basic_word", {48'd0, seen[k]}, 64'(k + 1));
        check("basic_busy_low", {63'd0, busy}, 64'd0);

        // Backpressure: ready 1,0,0,1 repeating
        do_reset();
        bp_mode = 1'b1;
        expect_vec(va);
        drive_vec(va, 4'b1111);
        wait_drain("bp_drain");
        bp_mode = 1'b0;
        check("bp_count", 64'(seen.size()), 64'd4);
        if (seen.size() == 4) check("bp_word3", {48'd0, seen[3]}, 64'h0004);

        // Double buffer: B captured mid-stream of A, C dropped while B is held
        do_reset();
        va = 64'h000a_000b_000c_000d;
        vb = 64'h1111_2222_3333_4444;
        vc = 64'h9999_8888_7777_6666;
        expect_vec(va);
        expect_vec(vb);
        drive_vec(va, 4'b1111);
        tick();
        tick();
        drive_vec(vb, 4'b1111);
        @(negedge clk);
        check("dbuf_no_overflow", {63'd0, overflow_err}, 64'd0);
        drive_vec(vc, 4'b1111);
        @(negedge clk);
        check("dbuf_overflow", {63'd0, overflow_err}, 64'd1);
        wait_drain("dbuf_drain");
        check("dbuf_count", 64'(seen.size()), 64'd8);
        if (seen.size() == 8) check("dbuf_b_first", {48'd0, seen[4]}, 64'h4444);
        check_gap("dbuf_gap");

        // Capture coinciding with LOAD is accepted
        do_reset();
        expect_vec(va);
        expect_vec(vb);
        drive_vec(va, 4'b1111);
        tick();
        drive_vec(vb, 4'b1111);
        @(negedge clk);
        check("loadcap_busy", {63'd0, busy}, 64'd1);
        wait_drain("loadcap_drain");
        check("loadcap_overflow", {63'd0, overflow_err}, 64'd0);
        check("loadcap_count", 64'(seen.size()), 64'd8);
        check_gap("loadcap_gap");

        // Partial valid is ignored and flagged
        do_reset();
        drive_vec(vc, 4'b0101);
        n = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid || busy) n++;
        end
        check("partial_no_stream", 64'(n), 64'd0);
        check("partial_sync", {63'd0, sync_err}, 64'd1);
        tick();
        expect_vec(va);
        drive_vec(va, 4'b1111);
        wait_drain("partial_then_full");
        check("partial_full_count", 64'(seen.size()), 64'd4);
        check("partial_sync_sticky", {63'd0, sync_err}, 64'd1);

        // Reset after the 2nd transfer drops the rest of the vector
        do_reset();
        expect_vec(vb);
        drive_vec(vb, 4'b1111);
        n = 0;
        while (n < 50 && seen.size() < 2) begin
            tick();
            n++;
        end
        check("mid_two_xfers", 64'(seen.size()), 64'd2);
        rst = 1'b1;
        expq.delete();
        tick();
        rst = 1'b0;
        seen.delete();
        @(negedge clk);
        check("mid_valid", {63'd0, out_valid}, 64'd0);
        check("mid_busy", {63'd0, busy}, 64'd0);
        check("mid_sync", {63'd0, sync_err}, 64'd0);
        check("mid_overflow", {63'd0, overflow_err}, 64'd0);
        repeat (3) @(negedge clk);
        check("mid_no_tail", 64'(seen.size()), 64'd0);
        tick();
        expect_vec(va);
        drive_vec(va, 4'b1111);
        wait_drain("mid_fresh");
        if (seen.size() > 0) check("mid_fresh_first", {48'd0, seen[0]}, 64'h000d);

`ifdef LAYER_SER_ARGMAX_EN
        // Argmax: negative ignored, tie keeps lowest index
        do_reset();
        va = 64'h0008_0010_fff0_0010;
        expect_vec(va);
        drive_vec(va, 4'b1111);
        n = 0;
        while (n < 30 && !argmax_valid) begin
            @(negedge clk);
            n++;
        end
        check("argmax_pulse", {63'd0, argmax_valid}, 64'd1);
        check("argmax_idx", {62'd0, argmax_idx}, 64'd0);
        check("argmax_val", {48'd0, argmax_val}, 64'h0010);
        @(negedge clk);
        check("argmax_one_cycle", {63'd0, argmax_valid}, 64'd0);
        vb = 64'h7fff_8000_0001_0002;
        expect_vec(vb);
        tick();
        drive_vec(vb, 4'b1111);
        n = 0;
        while (n < 30 && !argmax_valid) begin
            @(negedge clk);
            n++;
        end
        check("argmax2_idx", {62'd0, argmax_idx}, 64'd3);
        check("argmax2_val", {48'd0, argmax_val}, 64'h7fff);
        wait_drain("argmax_drain");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
